line_buff_subsys: RTL and testbench
===================================

# line_buff_subsys

- Tiled VGA pixel-fetch subsystem: a single-port frame buffer RAM, two ping-pong line buffers and a fill controller.
- Turns the timing generator's pixel/line counters into the 12-bit RGB pixel for the current beam position.
- Sits between the frame-buffer initialiser/writer and the VGA colour output stage.
- Each frame-buffer word packs TILE_PER_ROW tiles. One tile is a TILE_WIDTH×TILE_WIDTH block of one colour.

## Interface
- WIDTH_PX, 640, active pixels per line
- HEIGHT_LNS, 480, active lines per frame
- H_B_PORCH_MAX_PX, 144, pixel count where the active region starts (sync + back porch)
- V_B_PORCH_MAX_LNS, 35, line count where the active region starts
- TILE_WIDTH, 4, tile edge in pixels/lines
- PXL_WIDTH, 12, bits per pixel (3×4-bit colour)
- TILE_PER_ROW, 5, tiles per frame-buffer word
- PXL_CTR_WIDTH / LN_CTR_WIDTH, 10 / 10, counter widths
- Derived values:
  - TILE_PER_LINE = WIDTH_PX/TILE_WIDTH (160)
  - TILE_ROWS = HEIGHT_LNS/TILE_WIDTH (120)
  - WORDS_PER_LINE = TILE_PER_LINE/TILE_PER_ROW (32)
  - FBUFF_DEPTH = TILE_ROWS×WORDS_PER_LINE (3840)
  - FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH) (12)
  - FBUFF_DATA_WIDTH = TILE_PER_ROW×PXL_WIDTH (60)

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset; synchronous and active-high
- pxl_cntr_i  in  PXL_CTR_WIDTH  current pixel counter
- ln_cntr_i  in  LN_CTR_WIDTH  current line counter
- fbuff_wr_en_i  in  1  frame-buffer write strobe
- fbuff_wr_addr_i  in  FBUFF_ADDR_WIDTH  write word address
- fbuff_wr_data_i  in  FBUFF_DATA_WIDTH  write word; tile t occupies bits [t*PXL_WIDTH +: PXL_WIDTH]
- disp_pxl_o  out  PXL_WIDTH  pixel for the current counters
- fill_busy_o  out  1  high while a line-buffer fill is in progress

## Operation
- **Frame buffer**
  - Single-port RAM, FBUFF_DEPTH × FBUFF_DATA_WIDTH, synchronous read with 1-cycle latency.
  - Contents are not cleared by reset.
  - Writes are accepted in any state, including while rst_i is high.
- **Tile mapping**
  - Active region: ln in [V_B_PORCH_MAX_LNS, +HEIGHT_LNS) and pxl in [H_B_PORCH_MAX_PX, +WIDTH_PX).
  - r = (ln − V_B_PORCH_MAX_LNS)/TILE_WIDTH; c = (pxl − H_B_PORCH_MAX_PX)/TILE_WIDTH.
  - Tile (r,c) is stored at word r×WORDS_PER_LINE + c/TILE_PER_ROW, slot c%TILE_PER_ROW.
- **Line buffers**
  - Two line buffers, buf0 and buf1, each holding TILE_PER_LINE pixels.
  - Tile row r is always held in buf[r%2].
- **Display output**
  - Inside the active region: disp_pxl_o = buf[r[0]][c].
  - Outside the active region: 0 (see Configuration).
- **Fill FSM states: IDLE → READ → DRAIN → IDLE**
  - READ: issues WORDS_PER_LINE consecutive reads, base address r×WORDS_PER_LINE.
  - DRAIN: one extra cycle to capture the last read word.
  - Word k, slot t is written to buf[sel][k×TILE_PER_ROW + t].
- **After reset release**
  - Fill buf0 with row 0, then buf1 with row 1, back-to-back.
- **Steady-state refill trigger**
  - Fires when ln = V_B_PORCH_MAX_LNS + TILE_WIDTH×r + TILE_WIDTH−1 and pxl = H_B_PORCH_MAX_PX + WIDTH_PX.
  - Refills buf[r%2] with row (r+2) mod TILE_ROWS.
  - At frame end, rows 0 and 1 are therefore preloaded for the next frame.
- **Write/read conflict**
  - If fbuff_wr_en_i is high while in READ, the write wins.
  - The read address does not advance that cycle; the fill resumes on the next cycle with no lost words.
- A trigger arriving while a fill is busy is queued (depth 1), never dropped.

## Timing
- disp_pxl_o is a combinational function of pxl_cntr_i, ln_cntr_i and the line-buffer registers: zero cycles latency relative to the counters.
- A fill takes WORDS_PER_LINE+1 cycles (33 by default) without write conflicts; add one cycle per conflicting write.
- fill_busy_o rises the cycle after the trigger and falls the cycle after the last slot is written.
- While rst_i is high: FSM = IDLE, both buffers = 0, fill_busy_o = 0, disp_pxl_o = 0, queue cleared.
- Reset asserted mid-fill aborts the fill; the initial two-row fill restarts after release.
- Pixel/line counter wrap is handled purely by the region compare; no counter state is held internally.

## Configuration
- LBUFF_BLANK_EN defined: disp_pxl_o = 0 whenever the counters are outside the active region.
- LBUFF_BLANK_EN undefined:
  - Outside the active region, disp_pxl_o holds the last active pixel value, held in a register updated each active cycle.
  - It is 0 after reset.

## Test plan
- Hold rst_i and write all 3840 words with a per-tile incrementing pattern. Release reset. fill_busy_o is high for 66 cycles, then 0. At ln=35, pxl=144, disp_pxl_o = word 0 slot 0.
- At ln=35, pxl=148: disp_pxl_o = word 0 slot 1. At ln=35, pxl=783: disp_pxl_o = word 31 slot 4. At ln=38, pxl=144: same as ln=35.
- At ln=39, pxl=144: disp_pxl_o = word 32 slot 0 (buf1). At ln=38, pxl=784: a refill starts, and buf0 later holds row 2 (words 64–95).
- Sweep a full 800×525 frame and compare every active pixel against the model. Compare the second frame as well, checking the row 0/1 wrap.
- Assert fbuff_wr_en_i on 3 cycles during a fill: fill length = 36 cycles and buffer contents are correct.
- Assert rst_i mid-fill: outputs go to 0 in the next cycle. After release, rows 0 and 1 are refilled.

Source files
------------

// File: rtl/line_buff_subsys.sv
// Tiled VGA pixel fetch: frame-buffer RAM, ping-pong line buffers and the fill controller that refills them.
// Define LBUFF_BLANK_EN to force disp_pxl_o to 0 outside the active region; by default the last active pixel is held.
module line_buff_subsys #(
    parameter int unsigned WIDTH_PX          = 640,
    parameter int unsigned HEIGHT_LNS        = 480,
    parameter int unsigned H_B_PORCH_MAX_PX  = 144,
    parameter int unsigned V_B_PORCH_MAX_LNS = 35,
    parameter int unsigned TILE_WIDTH        = 4,
    parameter int unsigned PXL_WIDTH         = 12,
    parameter int unsigned TILE_PER_ROW      = 5,
    parameter int unsigned PXL_CTR_WIDTH     = 10,
    parameter int unsigned LN_CTR_WIDTH      = 10,
    localparam int unsigned TILE_PER_LINE    = WIDTH_PX / TILE_WIDTH,
    localparam int unsigned TILE_ROWS        = HEIGHT_LNS / TILE_WIDTH,
    localparam int unsigned WORDS_PER_LINE   = TILE_PER_LINE / TILE_PER_ROW,
    localparam int unsigned FBUFF_DEPTH      = TILE_ROWS * WORDS_PER_LINE,
    localparam int unsigned FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH),
    localparam int unsigned FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [PXL_CTR_WIDTH-1:0]    pxl_cntr_i,
    input  logic [LN_CTR_WIDTH-1:0]     ln_cntr_i,
    input  logic                        fbuff_wr_en_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0] fbuff_wr_addr_i,
    input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_wr_data_i,
    output logic [PXL_WIDTH-1:0]        disp_pxl_o,
    output logic                        fill_busy_o
);

    localparam int unsigned COL_W  = $clog2(TILE_PER_LINE);
    localparam int unsigned ROW_W  = $clog2(TILE_ROWS);
    localparam int unsigned WIDX_W = $clog2(WORDS_PER_LINE);

    localparam logic [PXL_CTR_WIDTH-1:0] PXL_ACT_LO   = PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX);
    localparam logic [PXL_CTR_WIDTH-1:0] PXL_ACT_HI   = PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX + WIDTH_PX);
    localparam logic [PXL_CTR_WIDTH-1:0] PXL_TILE     = PXL_CTR_WIDTH'(TILE_WIDTH);
    localparam logic [LN_CTR_WIDTH-1:0]  LN_ACT_LO    = LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS);
    localparam logic [LN_CTR_WIDTH-1:0]  LN_ACT_HI    = LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS + HEIGHT_LNS);
    localparam logic [LN_CTR_WIDTH-1:0]  LN_TILE      = LN_CTR_WIDTH'(TILE_WIDTH);
    localparam logic [LN_CTR_WIDTH-1:0]  LN_TILE_LAST = LN_CTR_WIDTH'(TILE_WIDTH - 1);
    localparam logic [WIDX_W-1:0]        WIDX_LAST    = WIDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} fill_state_e;

    fill_state_e                 state_q, state_d;
    logic [FBUFF_DATA_WIDTH-1:0] fbuff_mem [FBUFF_DEPTH];
    logic [FBUFF_DATA_WIDTH-1:0] rd_data_q;
    logic [PXL_WIDTH-1:0]        lbuf0 [TILE_PER_LINE];
    logic [PXL_WIDTH-1:0]        lbuf1 [TILE_PER_LINE];

    logic [PXL_CTR_WIDTH-1:0]    pxl_off_c;
    logic [LN_CTR_WIDTH-1:0]     ln_off_c;
    logic                        ln_act_c, pxl_act_c, in_act_c, trig_c;
    logic [ROW_W-1:0]            row_c, trig_row_c;
    logic [COL_W-1:0]            col_c;
    logic [PXL_WIDTH-1:0]        cur_pxl_c;

    logic                        pend_vld_q, init_q;
    logic [ROW_W-1:0]            pend_row_q, fill_row_q, start_row_c;
    logic [WIDX_W-1:0]           rd_idx_q, cap_idx_q;
    logic                        cap_vld_q, cap_sel_q;
    logic                        start_c, rd_en_c;
    logic [FBUFF_ADDR_WIDTH-1:0] rd_addr_c;

    // Beam position to tile coordinates, plus the end-of-tile-row refill trigger
    always_comb begin
        pxl_off_c  = pxl_cntr_i - PXL_ACT_LO;
        ln_off_c   = ln_cntr_i - LN_ACT_LO;
        ln_act_c   = (ln_cntr_i >= LN_ACT_LO) && (ln_cntr_i < LN_ACT_HI);
        pxl_act_c  = (pxl_cntr_i >= PXL_ACT_LO) && (pxl_cntr_i < PXL_ACT_HI);
        in_act_c   = ln_act_c && pxl_act_c;
        row_c      = ROW_W'(ln_off_c / LN_TILE);
        col_c      = pxl_act_c ? COL_W'(pxl_off_c / PXL_TILE) : '0;
        trig_c     = ln_act_c && (pxl_cntr_i == PXL_ACT_HI) && ((ln_off_c % LN_TILE) == LN_TILE_LAST);
        trig_row_c = ROW_W'((32'(row_c) + 32'd2) % TILE_ROWS);
    end

    // Fill FSM next state; a write in READ steals the RAM port and stalls the read index
    always_comb begin
        state_d     = state_q;
        start_c     = 1'b0;
        rd_en_c     = 1'b0;
        start_row_c = pend_vld_q ? pend_row_q : trig_row_c;
        rd_addr_c   = FBUFF_ADDR_WIDTH'(fill_row_q) * FBUFF_ADDR_WIDTH'(WORDS_PER_LINE)
                    + FBUFF_ADDR_WIDTH'(rd_idx_q);
        case (state_q)
            S_IDLE: begin
                if (pend_vld_q || trig_c) begin
                    start_c = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (!fbuff_wr_en_i) begin
                    rd_en_c = 1'b1;
                    if (rd_idx_q == WIDX_LAST) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pend_vld_q || trig_c) begin
                    start_c = 1'b1;
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fill control registers; reset preloads row 0 and flags row 1 to follow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pend_vld_q  <= 1'b1;
            pend_row_q  <= '0;
            init_q      <= 1'b1;
            fill_row_q  <= '0;
            rd_idx_q    <= '0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= '0;
            cap_sel_q   <= 1'b0;
            fill_busy_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_busy_o <= (state_d != S_IDLE);
            cap_vld_q   <= rd_en_c;
            cap_idx_q   <= rd_idx_q;
            cap_sel_q   <= fill_row_q[0];
            if (start_c) begin
                fill_row_q <= start_row_c;
                rd_idx_q   <= '0;
            end else if (rd_en_c) begin
                rd_idx_q <= rd_idx_q + WIDX_W'(1);
            end
            if (start_c && init_q) begin
                pend_vld_q <= 1'b1;
                pend_row_q <= ROW_W'(1);
                init_q     <= 1'b0;
            end else if (start_c && pend_vld_q) begin
                pend_vld_q <= trig_c;
                pend_row_q <= trig_row_c;
            end else if (trig_c && !start_c) begin
                pend_vld_q <= 1'b1;
                pend_row_q <= trig_row_c;
            end
        end
    end

    // Single-port frame buffer, not reset; writes take priority over fill reads
    always_ff @(posedge clk_i) begin
        if (fbuff_wr_en_i) begin
            fbuff_mem[fbuff_wr_addr_i] <= fbuff_wr_data_i;
        end else if (rd_en_c) begin
            rd_data_q <= fbuff_mem[rd_addr_c];
        end
    end

    // Unpack each returned word into TILE_PER_ROW consecutive line-buffer slots
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TILE_PER_LINE; i++) begin
                lbuf0[i] <= '0;
                lbuf1[i] <= '0;
            end
        end else if (cap_vld_q) begin
            for (int t = 0; t < TILE_PER_ROW; t++) begin
                if (cap_sel_q)
                    lbuf1[COL_W'(cap_idx_q) * COL_W'(TILE_PER_ROW) + COL_W'(t)] <= rd_data_q[t*PXL_WIDTH +: PXL_WIDTH];
                else
                    lbuf0[COL_W'(cap_idx_q) * COL_W'(TILE_PER_ROW) + COL_W'(t)] <= rd_data_q[t*PXL_WIDTH +: PXL_WIDTH];
            end
        end
    end

    assign cur_pxl_c = row_c[0] ? lbuf1[col_c] : lbuf0[col_c];

`ifdef LBUFF_BLANK_EN
    assign disp_pxl_o = (in_act_c && !rst_i) ? cur_pxl_c : '0;
`else
    logic [PXL_WIDTH-1:0] last_pxl_q;

    // Last active pixel, shown through the blanking intervals
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_pxl_q <= '0;
        end else if (in_act_c) begin
            last_pxl_q <= cur_pxl_c;
        end
    end

    assign disp_pxl_o = rst_i ? '0 : (in_act_c ? cur_pxl_c : last_pxl_q);
`endif

endmodule

// File: tb/tb_line_buff_subsys.sv
// Self-checking bench for line_buff_subsys: scoreboard of expected pixels built from a frame-buffer model.
module tb_line_buff_subsys;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 60;
    localparam int unsigned PW    = 12;
    localparam int unsigned DEPTH = 3840;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [9:0]    pxl_cntr_i = '0;
    logic [9:0]    ln_cntr_i = '0;
    logic          fbuff_wr_en_i = 1'b0;
    logic [AW-1:0] fbuff_wr_addr_i = '0;
    logic [DW-1:0] fbuff_wr_data_i = '0;
    logic [PW-1:0] disp_pxl_o;
    logic          fill_busy_o;

    always #5 clk_i = ~clk_i;

    line_buff_subsys dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pxl_cntr_i     (pxl_cntr_i),
        .ln_cntr_i      (ln_cntr_i),
        .fbuff_wr_en_i  (fbuff_wr_en_i),
        .fbuff_wr_addr_i(fbuff_wr_addr_i),
        .fbuff_wr_data_i(fbuff_wr_data_i),
        .disp_pxl_o     (disp_pxl_o),
        .fill_busy_o    (fill_busy_o)
    );

    logic [DW-1:0] fb_model [DEPTH];
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] last_exp = '0;
    logic [PW-1:0] exp_v;
    int            n_checks = 0;
    int            n_fail = 0;
    int            blen;
    bit            bhi;

    function automatic logic [DW-1:0] pat_word(input int w, input int seed);
        logic [DW-1:0] d;
        for (int t = 0; t < 5; t++) d[t*PW +: PW] = PW'(w * 5 + t + seed);
        return d;
    endfunction

    // Expected pixel from the frame-buffer contents and the tile mapping
    function automatic logic [PW-1:0] model_pxl(input int ln, input int pxl);
        logic [DW-1:0] w;
        int r, c;
        if (ln >= 35 && ln < 515 && pxl >= 144 && pxl < 784) begin
            r = (ln - 35) / 4;
            c = (pxl - 144) / 4;
            w = fb_model[r * 32 + c / 5];
            last_exp = w[(c % 5) * PW +: PW];
            return last_exp;
        end
`ifdef LBUFF_BLANK_EN
        return '0;
`else
        return last_exp;
`endif
    endfunction

    task automatic drive(input int ln, input int pxl);
        @(posedge clk_i); #1;
        ln_cntr_i  = 10'(ln);
        pxl_cntr_i = 10'(pxl);
        exp_q.push_back(model_pxl(ln, pxl));
    endtask

    task automatic write_word(input int a, input logic [DW-1:0] d);
        @(posedge clk_i); #1;
        fbuff_wr_en_i   = 1'b1;
        fbuff_wr_addr_i = AW'(a);
        fbuff_wr_data_i = d;
        fb_model[a]     = d;
    endtask

    task automatic end_write;
        @(posedge clk_i); #1;
        fbuff_wr_en_i = 1'b0;
    endtask

    // Busy-pulse length with counters parked in blanking; optional stolen cycles via writes
    task automatic measure_busy(input bit inject, output int len, output bit first_hi);
        bit seen;
        len = 0; seen = 0; first_hi = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk_i); #1;
            pxl_cntr_i = 10'd785;
            if (inject && (k == 5 || k == 10 || k == 15)) begin
                fbuff_wr_en_i   = 1'b1;
                fbuff_wr_addr_i = AW'(1000 + k / 5 - 1);
                fbuff_wr_data_i = pat_word(2000 + k, 3);
                fb_model[1000 + k / 5 - 1] = fbuff_wr_data_i;
            end else begin
                fbuff_wr_en_i = 1'b0;
            end
            @(negedge clk_i);
            if (k == 0) first_hi = fill_busy_o;
            if (fill_busy_o) begin
                len++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        fbuff_wr_en_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; ln_cntr_i = 10'd35; pxl_cntr_i = 10'd144;
        repeat (2) @(posedge clk_i);
        for (int a = 0; a < DEPTH; a++) write_word(a, pat_word(a, 1));
        end_write();
        @(negedge clk_i);
        n_checks++;
        if (disp_pxl_o !== '0) begin n_fail++; $display("FAIL reset_disp got %h want 0", disp_pxl_o); end
        n_checks++;
        if (fill_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", fill_busy_o); end
        ln_cntr_i = '0; pxl_cntr_i = '0; last_exp = '0;
        @(posedge clk_i); #1 rst_i = 1'b0;
        measure_busy(1'b0, blen, bhi);
        n_checks++;
        if (bhi !== 1'b1) begin n_fail++; $display("FAIL init_busy_rise got %b want 1", bhi); end
        n_checks++;
        if (blen != 66) begin n_fail++; $display("FAIL init_fill_len got %0d want 66", blen); end
    endtask

    task automatic test_tile_map;
        int lns [12] = '{35, 35, 35, 38, 39, 42, 36, 0, 520, 40, 37, 600};
        int pxs [12] = '{144, 148, 783, 144, 144, 783, 500, 0, 300, 783, 700, 144};
        for (int i = 0; i < 12; i++) begin
            drive(lns[i], pxs[i]);
            @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
            if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL tile_map ln=%0d pxl=%0d got %h want %h", lns[i], pxs[i], disp_pxl_o, exp_v); end
        end
        drive(38, 784);
        @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
        if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL trig_hold got %h want %h", disp_pxl_o, exp_v); end
        n_checks++;
        if (fill_busy_o !== 1'b0) begin n_fail++; $display("FAIL trig_busy_early got %b want 0", fill_busy_o); end
        measure_busy(1'b0, blen, bhi);
        n_checks++;
        if (bhi !== 1'b1) begin n_fail++; $display("FAIL trig_busy_rise got %b want 1", bhi); end
        n_checks++;
        if (blen != 33) begin n_fail++; $display("FAIL fill_len got %0d want 33", blen); end
        for (int c = 0; c < 160; c++) begin
            drive(43 + c % 4, 144 + 4 * c + c % 4);
            @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
            if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL row2 col=%0d got %h want %h", c, disp_pxl_o, exp_v); end
        end
    endtask

    task automatic test_write_conflict;
        drive(42, 784);
        @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
        if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL conf_trig got %h want %h", disp_pxl_o, exp_v); end
        measure_busy(1'b1, blen, bhi);
        n_checks++;
        if (blen != 36) begin n_fail++; $display("FAIL conflict_fill_len got %0d want 36", blen); end
        for (int c = 0; c < 160; c++) begin
            drive(47 + (c % 4), 144 + 4 * c + (c / 7) % 4);
            @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
            if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL row3 col=%0d got %h want %h", c, disp_pxl_o, exp_v); end
        end
        drive(45, 200);
        @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
        if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL row2_kept got %h want %h", disp_pxl_o, exp_v); end
    endtask

    task automatic test_reset_mid_fill;
        int lns [4] = '{35, 40, 42, 36};
        int pxs [4] = '{144, 600, 783, 783};
        drive(38, 784);
        @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
        if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL mid_trig got %h want %h", disp_pxl_o, exp_v); end
        repeat (10) begin @(posedge clk_i); #1 pxl_cntr_i = 10'd785; end
        @(posedge clk_i); #1;
        rst_i = 1'b1; ln_cntr_i = 10'd35; pxl_cntr_i = 10'd144;
        @(posedge clk_i); @(negedge clk_i);
        n_checks++;
        if (disp_pxl_o !== '0) begin n_fail++; $display("FAIL midrst_disp got %h want 0", disp_pxl_o); end
        n_checks++;
        if (fill_busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", fill_busy_o); end
        ln_cntr_i = '0; pxl_cntr_i = '0; last_exp = '0;
        @(posedge clk_i); #1 rst_i = 1'b0;
        measure_busy(1'b0, blen, bhi);
        n_checks++;
        if (blen != 66) begin n_fail++; $display("FAIL refill_len got %0d want 66", blen); end
        for (int i = 0; i < 4; i++) begin
            drive(lns[i], pxs[i]);
            @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
            if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL refill ln=%0d pxl=%0d got %h want %h", lns[i], pxs[i], disp_pxl_o, exp_v); end
        end
    endtask

    // Two frames; rows 0/1 are rewritten mid-frame so the second frame proves the wrap refill
    task automatic test_frame_sweep;
        int pxl;
        for (int f = 0; f < 2; f++) begin
            for (int ln = 0; ln < 525; ln++) begin
                if (f == 0 && ln == 50) begin
                    for (int a = 0; a < 64; a++) write_word(a, pat_word(a, 9));
                    end_write();
                end
                if (ln >= 35 && ln < 515) begin
                    for (int s = 0; s < (((ln - 35) % 4 == 1) ? 160 : 6); s++) begin
                        pxl = ((ln - 35) % 4 == 1) ? 144 + 4 * s + int'($urandom_range(0, 3))
                                                   : int'($urandom_range(144, 783));
                        drive(ln, pxl);
                        @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
                        if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL sweep f=%0d ln=%0d pxl=%0d got %h want %h", f, ln, pxl, disp_pxl_o, exp_v); end
                    end
                    if ((ln - 35) % 4 == 3) begin
                        for (int k = 0; k < 35; k++) begin
                            drive(ln, (784 + k) % 800);
                            @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
                            if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL hblank f=%0d ln=%0d k=%0d got %h want %h", f, ln, k, disp_pxl_o, exp_v); end
                        end
                    end
                end else begin
                    pxl = int'($urandom_range(0, 799));
                    drive(ln, pxl);
                    @(negedge clk_i); exp_v = exp_q.pop_front(); n_checks++;
                    if (disp_pxl_o !== exp_v) begin n_fail++; $display("FAIL vblank f=%0d ln=%0d pxl=%0d got %h want %h", f, ln, pxl, disp_pxl_o, exp_v); end
                end
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tile_map();
        test_write_conflict();
        test_reset_mid_fill();
        test_frame_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
